mix_columns_iter: RTL and testbench

//  AES MixColumns stage directly downstream of shift_rows in the SIMD execute stage.
//  - Takes the 4x32 state vector, one 32-bit word per column, byte [31:24] = row 0.
//  - Processes one column per clock through a single shared GF(2^8) column mixer.
//  - Decoupled by valid/ready handshakes on both sides; optional bypass for the final AES round.

---
 rtl/simd_aes_pkg.sv | 32 +++
 rtl/mix_columns_iter_if.sv | 41 ++++
 rtl/gf_mix_col.sv | 56 +++++
 rtl/mix_columns_iter.sv | 111 +++++++++++
 tb/tb_mix_columns_iter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/simd_aes_pkg.sv
// Shared AES helpers for the SIMD execute stage: the MixColumns FSM state
// encoding, the AES field polynomial and GF(2^8) arithmetic helpers.
package simd_aes_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

  // Reduction constant for x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1b;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Stream interface for mix_columns_iter. Optional macro: INV_MIX_COLUMNS_EN
// adds the `inv` select, sampled together with vect_in.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised the producer holds
// valid and its data stable until that edge. ready may depend combinationally
// on the other side's ready (in_ready follows out_ready while a result is
// waiting), but never on the same side's valid.
interface mix_columns_iter_if #(
  parameter int regSize = 32,
  parameter int vecSize = 4
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            bypass;
  logic [vecSize-1:0][regSize-1:0] vect_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [vecSize-1:0][regSize-1:0] vect_out;
`ifdef INV_MIX_COLUMNS_EN
  logic                            inv;
`endif

  // Upstream producer / downstream consumer side (testbench or neighbours).
  modport master (
`ifdef INV_MIX_COLUMNS_EN
    output inv,
`endif
    output in_valid, bypass, vect_in, out_ready,
    input  in_ready, out_valid, vect_out
  );

  // The MixColumns block itself.
  modport slave (
`ifdef INV_MIX_COLUMNS_EN
    input  inv,
`endif
    input  in_valid, bypass, vect_in, out_ready,
    output in_ready, out_valid, vect_out
  );
endinterface

// File: rtl/gf_mix_col.sv
// Combinational single-column (Inv)MixColumns. Byte [31:24] is row 0.
// Optional macro: INV_MIX_COLUMNS_EN adds `inv` to select coefficients
// {0e,0b,0d,09} instead of {02,03,01,01}.
module gf_mix_col
  import simd_aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef INV_MIX_COLUMNS_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  // One output row: dot product of a rotated coefficient row with the column.
  function automatic logic [7:0] dot4(
    input logic [7:0] c0, input logic [7:0] c1,
    input logic [7:0] c2, input logic [7:0] c3,
    input logic [7:0] x0, input logic [7:0] x1,
    input logic [7:0] x2, input logic [7:0] x3
  );
    return gmul(c0, x0) ^ gmul(c1, x1) ^ gmul(c2, x2) ^ gmul(c3, x3);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] c0, c1, c2, c3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Coefficient row 0; later rows are right-rotations of it.
  always_comb begin
    c0 = 8'h02;
    c1 = 8'h03;
    c2 = 8'h01;
    c3 = 8'h01;
`ifdef INV_MIX_COLUMNS_EN
    if (inv) begin
      c0 = 8'h0e;
      c1 = 8'h0b;
      c2 = 8'h0d;
      c3 = 8'h09;
    end
`endif
  end

  // Circulant matrix times column.
  always_comb begin
    col_out[31:24] = dot4(c0, c1, c2, c3, a0, a1, a2, a3);
    col_out[23:16] = dot4(c3, c0, c1, c2, a0, a1, a2, a3);
    col_out[15:8]  = dot4(c2, c3, c0, c1, a0, a1, a2, a3);
    col_out[7:0]   = dot4(c1, c2, c3, c0, a0, a1, a2, a3);
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per clock through a shared mixer,
// valid/ready on both sides, bypass for the final round.
// Optional macro: INV_MIX_COLUMNS_EN adds the `inv` select (InvMixColumns).
module mix_columns_iter
  import simd_aes_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  mix_columns_iter_if.slave            io,
  output mc_state_t                    dbg_state,
  output logic [$clog2(vecSize)-1:0]   dbg_col_cnt
);

  localparam int CW = $clog2(vecSize);
  localparam logic [CW-1:0] LAST_COL = CW'(vecSize - 1);

  typedef logic [vecSize-1:0][regSize-1:0] vec_t;

  mc_state_t          state_q, state_d;
  logic [CW-1:0]      col_cnt_q, col_cnt_d;
  vec_t               sbuf_q, sbuf_d;
  vec_t               vect_out_q, vect_out_d;
  logic               in_ready;
  logic               accept;
  logic [regSize-1:0] mix_out;
`ifdef INV_MIX_COLUMNS_EN
  logic               inv_q, inv_d;
`endif

  // A finished result retiring this cycle frees the slot, so DONE can accept
  // back-to-back without a bubble.
  assign in_ready = (state_q == MC_IDLE) | ((state_q == MC_DONE) & io.out_ready);
  assign accept   = io.in_valid & in_ready;

  assign io.in_ready  = in_ready;
  assign io.out_valid = (state_q == MC_DONE);
  assign io.vect_out  = vect_out_q;
  assign dbg_state    = state_q;
  assign dbg_col_cnt  = col_cnt_q;

  gf_mix_col u_mix (
    .col_in  (sbuf_q[col_cnt_q]),
`ifdef INV_MIX_COLUMNS_EN
    .inv     (inv_q),
`endif
    .col_out (mix_out)
  );

  // Next-state: column sweep in BUSY, retire in DONE, accept overrides both.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    sbuf_d     = sbuf_q;
    vect_out_d = vect_out_q;
`ifdef INV_MIX_COLUMNS_EN
    inv_d      = inv_q;
`endif
    case (state_q)
      MC_BUSY: begin
        vect_out_d[col_cnt_q] = mix_out;
        col_cnt_d             = col_cnt_q + 1'b1;
        if (col_cnt_q == LAST_COL) begin
          state_d   = MC_DONE;
          col_cnt_d = '0;
        end
      end
      MC_DONE: begin
        if (io.out_ready) state_d = MC_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      sbuf_d    = io.vect_in;
      col_cnt_d = '0;
`ifdef INV_MIX_COLUMNS_EN
      inv_d     = io.inv;
`endif
      if (io.bypass) begin
        vect_out_d = io.vect_in;
        state_d    = MC_DONE;
      end else begin
        state_d    = MC_BUSY;
      end
    end
  end

  // State registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MC_IDLE;
      col_cnt_q  <= '0;
      sbuf_q     <= '0;
      vect_out_q <= '0;
`ifdef INV_MIX_COLUMNS_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      sbuf_q     <= sbuf_d;
      vect_out_q <= vect_out_d;
`ifdef INV_MIX_COLUMNS_EN
      inv_q      <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed testbench for mix_columns_iter. With INV_MIX_COLUMNS_EN defined
// the inverse-transform vectors are exercised as well.
module tb_mix_columns_iter;
  import simd_aes_pkg::*;

  typedef logic [3:0][31:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mix_columns_iter_if #(.regSize(32), .vecSize(4)) io ();
  mc_state_t  dbg_state;
  logic [1:0] dbg_col_cnt;

  mix_columns_iter #(.regSize(32), .vecSize(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (io),
    .dbg_state   (dbg_state),
    .dbg_col_cnt (dbg_col_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one state, return at the negedge after the accepting edge.
  task automatic send(input vec_t v, input logic byp);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.vect_in  = v;
    io.bypass   = byp;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.bypass   = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_out(input string tag, input int exp_lat);
    int edges;
    edges = 1;
    while (io.out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 128'(edges), 128'(exp_lat));
  endtask

  // Compare the held result with the scoreboard head, then retire it.
  task automatic pop_result(input string tag);
    logic [127:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    check({tag, " out_valid"}, 128'(io.out_valid), 128'(1));
    check({tag, " vect_out"}, io.vect_out, e);
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready = 1'b0;
    check({tag, " retired"}, 128'(io.out_valid), 128'(0));
    check({tag, " in_ready"}, 128'(io.in_ready), 128'(1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    vec_t v1, m1, v2, m2;
    v1 = {4{32'hdb135345}};
    m1 = {4{32'h8e4da1bc}};
    v2 = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5};
    m2 = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6};

    io.in_valid  = 1'b0;
    io.bypass    = 1'b0;
    io.vect_in   = '0;
    io.out_ready = 1'b0;
`ifdef INV_MIX_COLUMNS_EN
    io.inv       = 1'b0;
`endif

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", 128'(io.out_valid), 128'(0));
    check("reset in_ready", 128'(io.in_ready), 128'(1));
    check("reset vect_out", io.vect_out, 128'(0));
    check("reset state", 128'(dbg_state), 128'(MC_IDLE));
    check("reset col_cnt", 128'(dbg_col_cnt), 128'(0));

    // 1: uniform column.
    exp_q.push_back(m1);
    send(v1, 1'b0);
    check("t1 busy", 128'(dbg_state), 128'(MC_BUSY));
    check("t1 busy in_ready", 128'(io.in_ready), 128'(0));
    wait_out("t1", 5);
    pop_result("t1");

    // 2: four distinct columns.
    exp_q.push_back(m2);
    send(v2, 1'b0);
    wait_out("t2", 5);
    pop_result("t2");

    // 3: bypass passes the input through in one edge.
    exp_q.push_back(v2);
    send(v2, 1'b1);
    wait_out("t3", 1);
    pop_result("t3");

    // 4: backpressure hold, then retire and accept on the same edge.
    exp_q.push_back(m1);
    send(v1, 1'b0);
    wait_out("t4a", 5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t4 hold out_valid", 128'(io.out_valid), 128'(1));
      check("t4 hold vect_out", io.vect_out, exp_q[0]);
      check("t4 hold in_ready", 128'(io.in_ready), 128'(0));
    end
    io.in_valid  = 1'b1;
    io.vect_in   = v2;
    io.bypass    = 1'b0;
    io.out_ready = 1'b1;
    #1;
    check("t4 same-edge in_ready", 128'(io.in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(m2);
    check("t4 retired", 128'(io.out_valid), 128'(0));
    check("t4 accepted", 128'(dbg_state), 128'(MC_BUSY));
    wait_out("t4b", 5);
    pop_result("t4b");

    // 5: reset in the middle of the column sweep.
    send(v1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t5 col_cnt before rst", 128'(dbg_col_cnt), 128'(2));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5 out_valid", 128'(io.out_valid), 128'(0));
    check("t5 vect_out", io.vect_out, 128'(0));
    check("t5 in_ready", 128'(io.in_ready), 128'(1));
    check("t5 state", 128'(dbg_state), 128'(MC_IDLE));
    exp_q.push_back(m2);
    send(v2, 1'b0);
    wait_out("t5", 5);
    pop_result("t5");

`ifdef INV_MIX_COLUMNS_EN
    // 6: inverse transform undoes the forward vectors.
    io.inv = 1'b1;
    exp_q.push_back(v1);
    send(m1, 1'b0);
    wait_out("t6a", 5);
    pop_result("t6a");
    exp_q.push_back(v2);
    send(m2, 1'b0);
    wait_out("t6b", 5);
    pop_result("t6b");
    io.inv = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
